// File: rtl/readback_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : readback_reader                                            |
// | Description : Sequences the RDBK primitive (TRIG pulse, wait for RIP),   |
// |               deserializes the DATA stream MSB-first into words, and     |
// |               buffers them in a small FIFO drained by a valid/ready port.|
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module readback_reader #(
    parameter int WORD_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TRIG_CYCLES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  rdbk_trig,
    input  logic                  rdbk_data,
    input  logic                  rdbk_rip,
    output logic                  busy,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  out_partial,
    output logic                  overflow,
    output logic                  timeout
);

    localparam int c_TCW = $clog2(TRIG_CYCLES + 1);
    localparam int c_TOW = $clog2(TIMEOUT + 1);
    localparam int c_BCW = $clog2(WORD_WIDTH + 1);
    localparam int c_PW  = $clog2(FIFO_DEPTH);
    localparam int c_CW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_TCW-1:0] c_TRIG_LAST = c_TCW'(TRIG_CYCLES - 1);
    localparam logic [c_TOW-1:0] c_TO_LAST   = c_TOW'(TIMEOUT);
    localparam logic [c_BCW-1:0] c_WORD_BITS = c_BCW'(WORD_WIDTH);
    localparam logic [c_BCW-1:0] c_LAST_BIT  = c_BCW'(WORD_WIDTH - 1);
    localparam logic [c_CW-1:0]  c_FULL      = c_CW'(FIFO_DEPTH);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_TRIG  = 3'd1;
    localparam logic [2:0] c_S_WAIT  = 3'd2;
    localparam logic [2:0] c_S_SHIFT = 3'd3;
    localparam logic [2:0] c_S_FLUSH = 3'd4;

    logic [2:0]            r_state;
    logic [c_TCW-1:0]      r_trig_cnt;
    logic [c_TOW-1:0]      r_to_cnt;
    logic [c_BCW-1:0]      r_bitcnt;
    logic [WORD_WIDTH-1:0] r_shreg;
    logic                  r_data_q;
    logic                  r_rip_q;
    logic                  r_trig;
    logic                  r_overflow;
    logic                  r_timeout;

    logic [WORD_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic                  r_mem_part [FIFO_DEPTH];
    logic [c_PW-1:0]       r_wr_ptr;
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;

    logic [WORD_WIDTH-1:0] w_shifted;
    logic                  w_push;
    logic [WORD_WIDTH-1:0] w_push_data;
    logic                  w_push_part;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push_ok;
    logic                  w_drop;

    assign w_shifted = {r_shreg[WORD_WIDTH-2:0], r_data_q};

    // Word-complete and flush pushes into the FIFO
    always_comb begin
        w_push      = 1'b0;
        w_push_data = w_shifted;
        w_push_part = 1'b0;
        if (r_state == c_S_SHIFT && r_rip_q && r_bitcnt == c_LAST_BIT) begin
            w_push = 1'b1;
        end else if (r_state == c_S_FLUSH && r_bitcnt != '0) begin
            w_push      = 1'b1;
            w_push_data = r_shreg << (c_WORD_BITS - r_bitcnt);
            w_push_part = 1'b1;
        end
    end

    assign w_pop     = (r_count != '0) && out_ready;
    assign w_full    = (r_count == c_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    // Single register stage on the RDBK inputs; everything below uses these
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_q <= 1'b0;
            r_rip_q  <= 1'b0;
        end else begin
            r_data_q <= rdbk_data;
            r_rip_q  <= rdbk_rip;
        end
    end

    // Readback sequencer, deserializer and sticky status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_trig_cnt <= '0;
            r_to_cnt   <= '0;
            r_bitcnt   <= '0;
            r_shreg    <= '0;
            r_trig     <= 1'b0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_overflow <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_trig     <= 1'b1;
                        r_trig_cnt <= '0;
                        r_state    <= c_S_TRIG;
                    end
                end
                c_S_TRIG: begin
                    if (r_trig_cnt == c_TRIG_LAST) begin
                        r_trig   <= 1'b0;
                        r_to_cnt <= '0;
                        r_state  <= c_S_WAIT;
                    end else begin
                        r_trig_cnt <= r_trig_cnt + 1'b1;
                    end
                end
                c_S_WAIT: begin
                    if (r_rip_q) begin
                        // The bit arriving with RIP is the first data bit
                        r_shreg  <= w_shifted;
                        r_bitcnt <= c_BCW'(1);
                        r_state  <= c_S_SHIFT;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= c_S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                c_S_SHIFT: begin
                    if (r_rip_q) begin
                        r_shreg  <= w_shifted;
                        r_bitcnt <= (r_bitcnt == c_LAST_BIT) ? '0 : r_bitcnt + 1'b1;
                    end else begin
                        r_state <= c_S_FLUSH;
                    end
                end
                c_S_FLUSH: begin
                    r_bitcnt <= '0;
                    r_state  <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
            // Drops can only occur outside IDLE, so this never races the clear
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_part[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem_data[r_wr_ptr] <= w_push_data;
                r_mem_part[r_wr_ptr] <= w_push_part;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdbk_trig   = r_trig;
    assign busy        = (r_state != c_S_IDLE);
    assign out_valid   = (r_count != '0);
    assign out_data    = r_mem_data[r_rd_ptr];
    assign out_partial = r_mem_part[r_rd_ptr];
    assign overflow    = r_overflow;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_readback_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_readback_reader                                         |
// | Description : Directed self-checking bench for readback_reader with a    |
// |               word-level scoreboard of expected FIFO contents.           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_readback_reader;

    localparam int c_W     = 8;
    localparam int c_DEPTH = 4;

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic           start     = 1'b0;
    logic           rdbk_data = 1'b0;
    logic           rdbk_rip  = 1'b0;
    logic           out_ready = 1'b0;
    logic           rdbk_trig;
    logic           busy;
    logic           out_valid;
    logic [c_W-1:0] out_data;
    logic           out_partial;
    logic           overflow;
    logic           timeout;

    readback_reader #(
        .WORD_WIDTH  (c_W),
        .FIFO_DEPTH  (c_DEPTH),
        .TRIG_CYCLES (2),
        .TIMEOUT     (1023)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rdbk_trig   (rdbk_trig),
        .rdbk_data   (rdbk_data),
        .rdbk_rip    (rdbk_rip),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .out_partial (out_partial),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_bad  = 0;
    bit         chk_en = 1'b0;
    logic [8:0] q_exp[$];   // {partial, word} in the order the consumer must see

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard compare: FIFO head against model head on every valid cycle
    always @(negedge clk) begin
        if (chk_en && out_valid === 1'b1) begin
            if (q_exp.size() == 0) begin
                check("valid_with_empty_model", 32'(out_valid), 32'd0);
            end else begin
                check("head_data", 32'(out_data), 32'(q_exp[0][7:0]));
                check("head_partial", 32'(out_partial), 32'(q_exp[0][8]));
                if (out_ready === 1'b1) begin
                    void'(q_exp.pop_front());
                end
            end
        end
    end

    // Split a bit stream into words MSB-first; track occupancy to predict drops
    task automatic model_enqueue(input logic [63:0] bits, input int n, input int ready_at,
                                 output bit exp_ovf);
        int       occ;
        int       rem;
        logic [7:0] w;
        occ     = q_exp.size();
        exp_ovf = 1'b0;
        for (int k = 0; k < n / 8; k++) begin
            w = 8'h00;
            for (int j = 0; j < 8; j++) begin
                w = {w[6:0], bits[n-1-(8*k+j)]};
            end
            if (occ < c_DEPTH) begin
                q_exp.push_back({1'b0, w});
                if (ready_at != 8 * (k + 1)) occ++;
            end else if (ready_at == 8 * (k + 1)) begin
                q_exp.push_back({1'b0, w});
            end else begin
                exp_ovf = 1'b1;
            end
        end
        rem = n % 8;
        if (rem != 0) begin
            w = 8'h00;
            for (int j = 0; j < rem; j++) begin
                w = {w[6:0], bits[rem-1-j]};
            end
            w = w << (8 - rem);
            if (occ < c_DEPTH) q_exp.push_back({1'b1, w});
            else               exp_ovf = 1'b1;
        end
    endtask

    task automatic do_start();
        int len;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clears_overflow", 32'(overflow), 32'd0);
        check("start_clears_timeout", 32'(timeout), 32'd0);
        len = 0;
        while (rdbk_trig === 1'b1 && len < 20) begin
            len++;
            tick();
        end
        check("trig_len", 32'(len), 32'd2);
    endtask

    // Drive n bits with RIP high right after TRIG ends; optional ready pulse
    // (pop) at iteration ready_at and optional reset at iteration reset_at.
    task automatic stream(input logic [63:0] bits, input int n, input int ready_at,
                          input int reset_at);
        bit exp_ovf;
        model_enqueue(bits, n, ready_at, exp_ovf);
        for (int i = 0; i <= n + 2; i++) begin
            if (i == reset_at) begin
                reset = 1'b1;
                start = 1'b0;
                out_ready = 1'b0;
                tick();
                reset     = 1'b0;
                rdbk_rip  = 1'b0;
                rdbk_data = 1'b0;
                q_exp.delete();
                check("rst_trig", 32'(rdbk_trig), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_valid", 32'(out_valid), 32'd0);
                check("rst_data", 32'(out_data), 32'd0);
                check("rst_partial", 32'(out_partial), 32'd0);
                check("rst_overflow", 32'(overflow), 32'd0);
                check("rst_timeout", 32'(timeout), 32'd0);
                return;
            end
            rdbk_rip  = (i < n);
            rdbk_data = (i < n) ? bits[n-1-i] : 1'b0;
            out_ready = (i == ready_at);
            start     = (i == 3);   // must be ignored while busy
            tick();
            if (i == n + 1) check("busy_in_flush", 32'(busy), 32'd1);
        end
        start     = 1'b0;
        out_ready = 1'b0;
        rdbk_rip  = 1'b0;
        check("busy_after_flush", 32'(busy), 32'd0);
        check("overflow_after_stream", 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic pop_lit(input logic [7:0] w, input logic p);
        check("lit_valid", 32'(out_valid), 32'd1);
        check("lit_data", 32'(out_data), 32'(w));
        check("lit_partial", 32'(out_partial), 32'(p));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        out_ready = 1'b1;
        while (out_valid === 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        out_ready = 1'b0;
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_model_empty", 32'(q_exp.size()), 32'd0);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        tick();
        tick();
        check("reset_trig", 32'(rdbk_trig), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_partial", 32'(out_partial), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        tick();

        // Two full words
        do_start();
        stream(64'hA53C, 16, -1, -1);
        pop_lit(8'hA5, 1'b0);
        pop_lit(8'h3C, 1'b0);
        drain();

        // Full word then zero-padded partial word
        do_start();
        stream(64'hACF, 12, -1, -1);
        pop_lit(8'hAC, 1'b0);
        pop_lit(8'hF0, 1'b1);
        drain();

        // Six words into a four-deep FIFO with no consumer
        do_start();
        stream(64'h1122_3344_5566, 48, -1, -1);
        check("t3_overflow", 32'(overflow), 32'd1);
        pop_lit(8'h11, 1'b0);
        drain();

        // RIP never arrives; start also clears the overflow left above
        do_start();
        k = 0;
        while (timeout !== 1'b1 && k < 1100) begin
            tick();
            k++;
        end
        check("t4_timeout_cycles", 32'(k), 32'd1024);
        check("t4_timeout", 32'(timeout), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_fifo_empty", 32'(out_valid), 32'd0);

        // Fill the FIFO, then pop exactly as the next word is pushed
        do_start();
        stream(64'hC1C2_C3C4, 32, -1, -1);
        check("t6_full_valid", 32'(out_valid), 32'd1);
        do_start();
        stream(64'h77, 8, 8, -1);
        check("t6_no_overflow", 32'(overflow), 32'd0);
        pop_lit(8'hC2, 1'b0);
        drain();

        // Reset five bits into a word, with a stale word sitting in the FIFO
        do_start();
        stream(64'h9E, 8, -1, -1);
        do_start();
        stream(64'hFFFF, 16, -1, 6);
        do_start();
        stream(64'h5AC3, 16, -1, -1);
        pop_lit(8'h5A, 1'b0);
        pop_lit(8'hC3, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
